// File: rtl/acs_pm_unit.sv
// Add-compare-select with registered path metrics for the 4-state K=3 rate-1/2 Viterbi trellis.
// Define ACS_PM_NORM_EN for modular normalisation; otherwise metrics saturate at 2^METRIC_W-1.
module acs_pm_unit #(
  parameter int unsigned METRIC_W = 4,
  parameter int unsigned BM_W     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic [BM_W-1:0]     i_BM_0,
  input  logic [BM_W-1:0]     i_BM_1,
  input  logic [BM_W-1:0]     i_BM_2,
  input  logic [BM_W-1:0]     i_BM_3,
  output logic                o_valid,
  output logic [METRIC_W-1:0] o_PM_0,
  output logic [METRIC_W-1:0] o_PM_1,
  output logic [METRIC_W-1:0] o_PM_2,
  output logic [METRIC_W-1:0] o_PM_3,
  output logic [3:0]          o_dec,
  output logic [1:0]          o_min_state,
  output logic                o_norm
);

  localparam logic [METRIC_W-1:0] PM_INIT = {1'b0, {(METRIC_W-1){1'b1}}};
  localparam logic [METRIC_W:0]   PM_MAX  = {1'b0, {METRIC_W{1'b1}}};

  logic [METRIC_W-1:0] r_pm [4];
  logic [3:0]          r_dec;
  logic                r_valid;
  logic                r_norm;

  logic [METRIC_W-1:0] w_pm_n [4];
  logic [METRIC_W:0]   w_a    [4];
  logic [METRIC_W:0]   w_b    [4];
  logic [METRIC_W:0]   w_sel  [4];
  logic [METRIC_W-1:0] w_new  [4];
  logic [3:0]          w_dec;
  logic                w_norm;

  function automatic logic [METRIC_W:0] add_bm(input logic [METRIC_W-1:0] pm,
                                               input logic [BM_W-1:0] bm);
    return {1'b0, pm} + {{(METRIC_W+1-BM_W){1'b0}}, bm};
  endfunction

`ifdef ACS_PM_NORM_EN
  // All four MSBs set: clearing them shifts every metric by the same amount.
  assign w_norm = r_pm[0][METRIC_W-1] & r_pm[1][METRIC_W-1] &
                  r_pm[2][METRIC_W-1] & r_pm[3][METRIC_W-1];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_pm_n[i] = w_norm ? {1'b0, r_pm[i][METRIC_W-2:0]} : r_pm[i];
    end
  end
`else
  assign w_norm = 1'b0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_pm_n[i] = r_pm[i];
    end
  end
`endif

  always_comb begin
    w_a[0] = add_bm(w_pm_n[0], i_BM_0);
    w_b[0] = add_bm(w_pm_n[1], i_BM_3);
    w_a[1] = add_bm(w_pm_n[2], i_BM_2);
    w_b[1] = add_bm(w_pm_n[3], i_BM_1);
    w_a[2] = add_bm(w_pm_n[0], i_BM_3);
    w_b[2] = add_bm(w_pm_n[1], i_BM_0);
    w_a[3] = add_bm(w_pm_n[2], i_BM_1);
    w_b[3] = add_bm(w_pm_n[3], i_BM_2);
  end

  // Compare on unclipped sums; clip only the survivor.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      w_dec[s] = (w_b[s] < w_a[s]);
      w_sel[s] = w_dec[s] ? w_b[s] : w_a[s];
      w_new[s] = (w_sel[s] > PM_MAX) ? PM_MAX[METRIC_W-1:0] : w_sel[s][METRIC_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pm[0] <= '0;
      r_pm[1] <= PM_INIT;
      r_pm[2] <= PM_INIT;
      r_pm[3] <= PM_INIT;
      r_dec   <= '0;
      r_valid <= 1'b0;
      r_norm  <= 1'b0;
    end else if (i_start) begin
      r_pm[0] <= '0;
      r_pm[1] <= PM_INIT;
      r_pm[2] <= PM_INIT;
      r_pm[3] <= PM_INIT;
      r_dec   <= '0;
      r_valid <= 1'b0;
      r_norm  <= 1'b0;
    end else if (i_valid) begin
      for (int s = 0; s < 4; s++) begin
        r_pm[s] <= w_new[s];
      end
      r_dec   <= w_dec;
      r_valid <= 1'b1;
      r_norm  <= w_norm;
    end else begin
      r_valid <= 1'b0;
      r_norm  <= 1'b0;
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    o_min_state = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (r_pm[i] < r_pm[o_min_state]) begin
        o_min_state = 2'(i);
      end
    end
  end

  assign o_PM_0  = r_pm[0];
  assign o_PM_1  = r_pm[1];
  assign o_PM_2  = r_pm[2];
  assign o_PM_3  = r_pm[3];
  assign o_dec   = r_dec;
  assign o_valid = r_valid;
  assign o_norm  = r_norm;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Self-checking bench for acs_pm_unit: behavioural trellis model, per-cycle compare, literal checks.
module tb_acs_pm_unit;

  localparam int W  = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, valid;
  logic [BW-1:0] bm0, bm1, bm2, bm3;
  logic          o_valid, o_norm;
  logic [W-1:0]  pm0, pm1, pm2, pm3;
  logic [3:0]    o_dec;
  logic [1:0]    o_min_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  acs_pm_unit #(.METRIC_W(W), .BM_W(BW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
    .i_BM_0(bm0), .i_BM_1(bm1), .i_BM_2(bm2), .i_BM_3(bm3),
    .o_valid(o_valid), .o_PM_0(pm0), .o_PM_1(pm1), .o_PM_2(pm2), .o_PM_3(pm3),
    .o_dec(o_dec), .o_min_state(o_min_state), .o_norm(o_norm)
  );

  always #5 clk = ~clk;

  // Trellis: predecessor state and branch-metric index of each candidate.
  int pa [4] = '{0, 2, 0, 2};
  int ba [4] = '{0, 2, 3, 1};
  int pb [4] = '{1, 3, 1, 3};
  int bb [4] = '{3, 1, 0, 2};

  int m_pm [4];
  int m_dec, m_valid, m_norm;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int bm [4];
    int p [4];
    int a, b, half, maxv;
    bit do_norm;
    half = 1 << (W - 1);
    maxv = (1 << W) - 1;
    if (!rst_n || start) begin
      m_pm = '{0, half - 1, half - 1, half - 1};
      m_dec = 0; m_valid = 0; m_norm = 0;
    end else if (valid) begin
      bm = '{int'(bm0), int'(bm1), int'(bm2), int'(bm3)};
      p = m_pm;
      do_norm = 0;
`ifdef ACS_PM_NORM_EN
      do_norm = (p[0] >= half) && (p[1] >= half) && (p[2] >= half) && (p[3] >= half);
`endif
      if (do_norm) for (int i = 0; i < 4; i++) p[i] -= half;
      m_dec = 0;
      for (int s = 0; s < 4; s++) begin
        a = p[pa[s]] + bm[ba[s]];
        b = p[pb[s]] + bm[bb[s]];
        if (b < a) m_dec |= (1 << s);
        m_pm[s] = (b < a) ? b : a;
        if (m_pm[s] > maxv) m_pm[s] = maxv;
      end
      m_valid = 1;
      m_norm = int'(do_norm);
    end else begin
      m_valid = 0; m_norm = 0;
    end
  end

  always @(negedge clk) begin
    int best;
    if (cmp_en) begin
      best = 0;
      for (int i = 1; i < 4; i++) if (m_pm[i] < m_pm[best]) best = i;
      chk("pm0", int'(pm0), m_pm[0]);
      chk("pm1", int'(pm1), m_pm[1]);
      chk("pm2", int'(pm2), m_pm[2]);
      chk("pm3", int'(pm3), m_pm[3]);
      chk("dec", int'(o_dec), m_dec);
      chk("valid", int'(o_valid), m_valid);
      chk("norm", int'(o_norm), m_norm);
      chk("min_state", int'(o_min_state), best);
    end
  end

  // Apply inputs, then return just after the edge that consumed them.
  task automatic drive(input bit s, input bit v, input int b0, input int b1, input int b2,
                       input int b3);
    start = s; valid = v;
    bm0 = BW'(b0); bm1 = BW'(b1); bm2 = BW'(b2); bm3 = BW'(b3);
    @(posedge clk);
    #1;
  endtask

`ifdef ACS_PM_NORM_EN
  int sat_pm0 [8] = '{3, 6, 9, 4, 7, 10, 5, 8};
  int sat_pm3 [8] = '{10, 6, 9, 4, 7, 10, 5, 8};
  int sat_nrm [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
`else
  int sat_pm0 [8] = '{3, 6, 9, 12, 15, 15, 15, 15};
  int sat_pm3 [8] = '{10, 6, 9, 12, 15, 15, 15, 15};
  int sat_nrm [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0;
    bm0 = '0; bm1 = '0; bm2 = '0; bm3 = '0;
    #12;
    chk("rst_pm0", int'(pm0), 0);
    chk("rst_pm1", int'(pm1), 7);
    chk("rst_pm3", int'(pm3), 7);
    chk("rst_dec", int'(o_dec), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_norm", int'(o_norm), 0);
    chk("rst_min", int'(o_min_state), 0);
    #1 rst_n = 1'b1;
    cmp_en = 1;

    drive(0, 1, 0, 1, 1, 2);
    chk("first_pm", {int'(pm0), int'(pm1), int'(pm2), int'(pm3)} == {0, 8, 2, 8} ? 1 : 0, 1);
    chk("first_dec", int'(o_dec), 0);
    chk("first_valid", int'(o_valid), 1);
    chk("first_min", int'(o_min_state), 0);

    // Ties: converge to all-equal metrics, then equal candidates.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("eq_pm", int'(pm0) + int'(pm1) + int'(pm2) + int'(pm3), 0);
    drive(0, 1, 1, 1, 1, 1);
    chk("tie_dec", int'(o_dec), 0);
    chk("tie_pm1", int'(pm1), 1);
    drive(0, 1, 3, 0, 0, 0);
    chk("tie_dec0", int'(o_dec[0]), 1);
    chk("tie_pm0", int'(pm0), 1);

    drive(0, 0, 3, 3, 3, 3);
    chk("idle_valid", int'(o_valid), 0);
    chk("idle_pm0", int'(pm0), 1);

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 3, 3, 3, 3);
      chk($sformatf("sat_pm0_%0d", i), int'(pm0), sat_pm0[i]);
      chk($sformatf("sat_pm3_%0d", i), int'(pm3), sat_pm3[i]);
      chk($sformatf("sat_norm_%0d", i), int'(o_norm), sat_nrm[i]);
    end

    drive(1, 1, 2, 1, 3, 0);
    chk("start_pm0", int'(pm0), 0);
    chk("start_pm2", int'(pm2), 7);
    chk("start_valid", int'(o_valid), 0);
    chk("start_dec", int'(o_dec), 0);

    drive(0, 1, 3, 2, 1, 0);
    drive(0, 1, 1, 2, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pm1", int'(pm1), 7);
    chk("async_pm0", int'(pm0), 0);
    chk("async_valid", int'(o_valid), 0);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      drive(r < 5, (r >= 5) && (r < 80), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
      if (r == 99) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
